// File: rtl/aes_key_expansion.sv
// -----------------------------------------------------------------------------
// aes_key_expansion
//
// Iterative AES-128 key schedule. It produces round keys 0..ROUNDS one per
// accepted valid/ready handshake. The keys feed the round key XOR stage, and
// the round controller consumes them in lockstep with the cipher state.
//
// Byte layout follows the state vector: byte(r,c) is at [127-8*(4c+r) -: 8].
// Word w0 is [127:96] and w3 is [31:0].
//
// Optional feature (macro AES_KEYEXP_REVERSE_EN):
//   Adds a `reverse` input that is sampled together with start. With
//   reverse=1 the block first runs forward to the last round key (PRECOMP).
//   It then emits keys ROUNDS..0 in descending order, which the inverse
//   cipher needs.
//
// Ports:
//   clk       in   1    rising-edge clock
//   reset     in   1    synchronous, active-high; clears all state
//   start     in   1    request expansion of key_in (honoured only in IDLE)
//   key_in    in   128  cipher key, captured on the accepted start cycle
//   reverse   in   1    (AES_KEYEXP_REVERSE_EN only) emit keys in descending order
//   rk_ready  in   1    consumer accepts rk_out this cycle
//   rk_valid  out  1    rk_out/rk_index hold a valid round key
//   rk_out    out  128  current round key
//   rk_index  out  4    round number of rk_out
//   busy      out  1    high whenever the FSM is not IDLE
//   done      out  1    one-cycle pulse after the final round key is accepted
// -----------------------------------------------------------------------------
module aes_key_expansion #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
`ifdef AES_KEYEXP_REVERSE_EN
  input  logic         reverse,
`endif
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  // The schedule below hardwires the AES-128 rcon sequence, so ROUNDS is fixed.
  if (ROUNDS != 10) begin : g_rounds_check
    $error("aes_key_expansion: only ROUNDS=10 is supported");
  end

  localparam logic [3:0] LAST    = 4'(ROUNDS);
  localparam logic [3:0] LAST_M1 = 4'(ROUNDS - 1);

  // AES forward S-box. Entry 0 sits in the top byte, so the entry for x lives
  // at bit offset 8*(255-x), which equals {~x, 3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EMIT
`ifdef AES_KEYEXP_REVERSE_EN
    , PRECOMP
`endif
  } state_t;

  state_t state;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // RotWord moves the top byte of the word to the bottom.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Forward step. Each new word is chained from the word produced just before it.
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] a, b, c, d, t;
    a = k[127:96] ^ (sub_word(rot_word(k[31:0])) ^ {rc, 24'h0});
    t = a;
    b = k[95:64] ^ t;
    c = k[63:32] ^ b;
    d = k[31:0]  ^ c;
    return {a, b, c, d};
  endfunction

  logic [127:0] fwd_key;
  assign fwd_key = next_key(rk_out, rcon(rk_index + 4'd1));

`ifdef AES_KEYEXP_REVERSE_EN
  // Inverse step. The words are recovered last-to-first because the recovered
  // d' is needed for the g() term that restores a'.
  function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] a, b, c, d;
    d = k[31:0]  ^ k[63:32];
    c = k[63:32] ^ k[95:64];
    b = k[95:64] ^ k[127:96];
    a = k[127:96] ^ sub_word(rot_word(d)) ^ {rc, 24'h0};
    return {a, b, c, d};
  endfunction

  logic [127:0] rev_key;
  logic         dir_rev;
  assign rev_key = prev_key(rk_out, rcon(rk_index));
`endif

  // Main control FSM. All outputs are registered. done is cleared every cycle
  // unless the final handshake happens, which makes it a single-cycle pulse.
  // In IDLE, start is also ignored while done is high, so a start arriving in
  // the done cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_index <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
      dir_rev  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rk_valid <= 1'b0;
          if (start && !done) begin
            rk_out   <= key_in;
            rk_index <= '0;
            busy     <= 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
            dir_rev  <= reverse;
            if (reverse) begin
              state    <= PRECOMP;
              rk_valid <= 1'b0;
            end else begin
              state    <= EMIT;
              rk_valid <= 1'b1;
            end
`else
            state    <= EMIT;
            rk_valid <= 1'b1;
`endif
          end
        end

`ifdef AES_KEYEXP_REVERSE_EN
        // Run forward to the last round key without emitting. The key becomes
        // valid on the same edge that produces it, so the first valid appears
        // ROUNDS+1 cycles after start.
        PRECOMP: begin
          rk_out   <= fwd_key;
          rk_index <= rk_index + 4'd1;
          if (rk_index == LAST_M1) begin
            state    <= EMIT;
            rk_valid <= 1'b1;
          end
        end
`endif

        EMIT: begin
          if (rk_ready) begin
`ifdef AES_KEYEXP_REVERSE_EN
            if (dir_rev ? (rk_index == 4'd0) : (rk_index == LAST)) begin
`else
            if (rk_index == LAST) begin
`endif
              state    <= IDLE;
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
            end else if (dir_rev) begin
              rk_out   <= rev_key;
              rk_index <= rk_index - 4'd1;
`endif
            end else begin
              rk_out   <= fwd_key;
              rk_index <= rk_index + 4'd1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          rk_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifndef AES_KEYEXP_REVERSE_EN
  // Only a forward step is needed in the default build.
  logic unused_last_m1;
  assign unused_last_m1 = ^LAST_M1;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expansion
//
// Directed, table-driven bench for aes_key_expansion. It uses the FIPS-197
// appendix A.1 key schedule as reference vectors. The bench also has
// hand-written sequences for stalls, ignored starts, mid-run reset and (when
// AES_KEYEXP_REVERSE_EN is defined) descending emission.
//
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_aes_key_expansion;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  vec_t fips_vec [0:10];

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
`ifdef AES_KEYEXP_REVERSE_EN
  logic         reverse;
`endif
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;

  int n_checks;
  int n_errors;

  aes_key_expansion #(.ROUNDS(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
`ifdef AES_KEYEXP_REVERSE_EN
    .reverse  (reverse),
`endif
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_index (rk_index),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait below never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic s, input logic [127:0] k, input logic r);
    start    = s;
    key_in   = k;
    rk_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // The caller drives start with FIPS_KEY just before calling this task.
  // The task follows the forward FIPS schedule. rk_ready is high on every
  // ready_period-th cycle. If poke_start is set, start is also pulsed with a
  // different key while round 3 is showing. The task returns on the done cycle.
  task automatic runSchedule(input int ready_period, input bit poke_start);
    int exp_idx;
    int cyc;
    bit poked;
    bit ready_now;
    exp_idx = 0;
    cyc     = 0;
    poked   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (exp_idx <= 10 && cyc < 200) begin
      checkFlag("fwd_valid", rk_valid, 1'b1);
      checkFlag("fwd_busy", busy, 1'b1);
      checkFlag("fwd_done_low", done, 1'b0);
      checkOutput("fwd_index", 128'(rk_index), 128'(fips_vec[exp_idx].idx));
      checkOutput("fwd_key", rk_out, fips_vec[exp_idx].key);
      ready_now = ((cyc % ready_period) == 0);
      rk_ready  = ready_now;
      if (poke_start && !poked && exp_idx == 3) begin
        start  = 1'b1;
        key_in = ALT_KEY;
        poked  = 1'b1;
      end else begin
        start  = 1'b0;
        key_in = FIPS_KEY;
      end
      if (ready_now) exp_idx++;
      cyc++;
      @(negedge clk);
    end
    if (exp_idx <= 10) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL fwd_timeout: got index %0d, required completion of index 10", exp_idx);
    end
    checkFlag("done_pulse", done, 1'b1);
    checkFlag("done_valid_low", rk_valid, 1'b0);
    checkFlag("done_busy_low", busy, 1'b0);
  endtask

  initial begin
    fips_vec[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    fips_vec[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_vec[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips_vec[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips_vec[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips_vec[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips_vec[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips_vec[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips_vec[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips_vec[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips_vec[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
    reverse = 1'b0;
`endif
    applyStimulus(1'b0, '0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    checkFlag("rst_valid", rk_valid, 1'b0);
    checkOutput("rst_key", rk_out, '0);
    checkOutput("rst_index", 128'(rk_index), '0);
    checkFlag("rst_busy", busy, 1'b0);
    checkFlag("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS key, continuous ready
    $display("[TB] forward schedule, rk_ready always high");
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    runSchedule(1, 1'b0);
    @(negedge clk);
    checkFlag("done_one_cycle", done, 1'b0);

    // FIPS key, ready pattern 1,0,0,1,0,0,...
    $display("[TB] forward schedule, stalled rk_ready");
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    runSchedule(3, 1'b0);
    @(negedge clk);
    checkFlag("stall_done_one_cycle", done, 1'b0);

    // Start at round 3 with another key is ignored, start in done cycle ignored
    $display("[TB] ignored start requests");
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    runSchedule(1, 1'b1);
    applyStimulus(1'b1, KEY2, 1'b1);
    @(negedge clk);
    checkFlag("done_cycle_start_valid", rk_valid, 1'b0);
    checkFlag("done_cycle_start_busy", busy, 1'b0);
    checkFlag("done_cycle_done_low", done, 1'b0);
    @(negedge clk);
    checkFlag("after_done_start_valid", rk_valid, 1'b1);
    checkOutput("after_done_start_index", 128'(rk_index), '0);
    checkOutput("key2_round0", rk_out, KEY2);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkFlag("key2_r10_valid", rk_valid, 1'b1);
    checkOutput("key2_r10_index", 128'(rk_index), 128'd10);
    checkOutput("key2_round10", rk_out, KEY2_R10);
    @(negedge clk);
    checkFlag("key2_done", done, 1'b1);
    @(negedge clk);

    // Reset while rk_index=5 abandons the run, a fresh start then works
    $display("[TB] reset mid-expansion");
    applyStimulus(1'b1, FIPS_KEY, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_index", 128'(rk_index), 128'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkFlag("mid_rst_valid", rk_valid, 1'b0);
    checkFlag("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_key", rk_out, '0);
    checkFlag("mid_rst_done", done, 1'b0);
    @(negedge clk);
    checkFlag("post_rst_no_done", done, 1'b0);
    applyStimulus(1'b1, KEY2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checkFlag("fresh_valid", rk_valid, 1'b1);
    checkOutput("fresh_index", 128'(rk_index), '0);
    checkOutput("fresh_round0", rk_out, KEY2);
    repeat (11) @(negedge clk);
    checkFlag("fresh_done", done, 1'b1);
    @(negedge clk);

`ifdef AES_KEYEXP_REVERSE_EN
    // Reverse emission: ROUNDS+1 cycles to the first key, then 10 down to 0
    begin
      int cnt;
      $display("[TB] reverse schedule");
      reverse = 1'b1;
      applyStimulus(1'b1, FIPS_KEY, 1'b1);
      cnt = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        cnt++;
        if (cnt == 1) begin
          checkFlag("rev_precomp_busy", busy, 1'b1);
          checkFlag("rev_precomp_valid", rk_valid, 1'b0);
        end
      end while (!rk_valid && cnt < 30);
      reverse = 1'b0;
      checkOutput("rev_latency", 128'(cnt), 128'd11);
      for (int i = 10; i >= 0; i--) begin
        checkFlag("rev_valid", rk_valid, 1'b1);
        checkFlag("rev_done_low", done, 1'b0);
        checkOutput("rev_index", 128'(rk_index), 128'(fips_vec[i].idx));
        checkOutput("rev_key", rk_out, fips_vec[i].key);
        @(negedge clk);
      end
      checkFlag("rev_done", done, 1'b1);
      checkFlag("rev_done_valid_low", rk_valid, 1'b0);
      @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule that generates round keys 0..10, one per accepted handshake, and feeds them to the round key XOR stage.
- Sits directly upstream of that stage. The round controller consumes rk_out in lockstep with the cipher state.
- Byte order matches the state vector: byte(r,c) at bits [127-8*(4c+r) -: 8]. Word w0 = [127:96], w3 = [31:0].
- S-box lookup for SubWord is local: a combinational 256-entry table, replicated 4x.

Parameters:
- ROUNDS, 10, index of the last round key. Only 10 is supported; other values are illegal and flagged by a generate-time $error.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  request expansion of key_in; sampled only in IDLE
- key_in  in  128  cipher key, sampled on the accepted start cycle
- rk_ready  in  1  consumer accepts rk_out this cycle
- rk_valid  out  1  rk_out/rk_index hold a valid round key
- rk_out  out  128  current round key
- rk_index  out  4  round number of rk_out (0..ROUNDS)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after round key ROUNDS is accepted

Behaviour:
- Reset values: rk_valid=0, rk_out=0, rk_index=0, busy=0, done=0, state=IDLE. Reset takes priority over all other inputs; reset mid-expansion abandons it with no done pulse.
- IDLE, start=1: next cycle state=EMIT, rk_out=key_in, rk_index=0, rk_valid=1, busy=1. Latency is 1 cycle from start to the first valid key.
- IDLE, start=0: hold outputs. rk_out keeps its last value; rk_valid=0.
- EMIT, rk_valid & rk_ready & rk_index<ROUNDS:
  - rk_out <= next(rk_out, rcon[rk_index+1]); rk_index++; rk_valid stays 1.
  - Throughput is one key per cycle under continuous rk_ready.
- EMIT, rk_ready=0: rk_out, rk_index and rk_valid held stable (no combinational change while stalled).
- EMIT, rk_ready=1 & rk_index==ROUNDS: next cycle state=IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle.
- start while busy is ignored, including the done cycle. A start in the cycle after done (IDLE) is accepted.
- next(): words a,b,c,d; t = SubWord(RotWord(d)) ^ {rcon,24'h0}; a'=a^t, b'=b^a', c'=c^b', d'=d^c'.
  - RotWord moves the top byte to the bottom.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- done and rk_valid are never high in the same cycle.

Optional Feature:
- Macro: AES_KEYEXP_REVERSE_EN.
- When defined, an extra input port `reverse` (1 bit) is present, sampled with start.
- reverse=0: behaviour identical to the base block.
- reverse=1: state PRECOMP runs ROUNDS cycles of forward next() with rk_valid=0 and busy=1, ignoring rk_ready. EMIT then starts at rk_index=ROUNDS with the round-10 key.
- Each reverse handshake applies prev(rk_out, rcon[rk_index]) and decrements rk_index:
  - d'=d^c, c'=c^b, b'=b^a;
  - a' = a ^ SubWord(RotWord(d')) ^ {rcon,24'h0}.
- Reverse termination: round key 0 is accepted, then done pulses. Reverse latency is ROUNDS+1 cycles from start to first rk_valid.
- When undefined: the port and PRECOMP state do not exist.

Test Plan:
- Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 constant:
  - rk_index 0 gives 2b7e1516...4f3c; rk_index 1 gives a0fafe1788542cb123a339392a6c7605; rk_index 10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles, then done=1 for one cycle.
- Same key, rk_ready toggling 1,0,0,1,... : rk_out/rk_index are stable through the stall cycles; the sequence of keys is identical to the first test; done occurs only after index 10 is accepted.
- Reset asserted while rk_index=5: next cycle rk_valid=0, busy=0, rk_out=0, no done. A fresh start then yields round key 0 equal to the new key_in.
- start pulsed at rk_index=3 with a different key_in: ignored, and expansion continues with the original key. start in the done cycle is also ignored.
- Key 000102030405060708090a0b0c0d0e0f: round 10 key is 13111d7fe3944a17f307a78b4d2b30c5.
- (AES_KEYEXP_REVERSE_EN) reverse=1 with the FIPS key:
  - First valid appears 11 cycles after start, with rk_index=10 and key d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Final key is rk_index=0, 2b7e151628aed2a6abf7158809cf4f3c, followed by done.
